// File: rtl/enc_serializer.sv
// enc_serializer: bit-serial output stage placed after the enumeration encoder.
// Encoded words of NBIT+1 bits are buffered in a DEPTH-word FIFO. Each word is
// shifted out MSB-first, one bit per out_valid/out_ready handshake.
// out_first marks the MSB and out_last marks the final bit of the frame.
// A wrapping counter tracks completed frames.
//
// Optional feature: define ENC_SER_PARITY_EN to append an even-parity bit
// (XOR of all data bits) after the LSB. out_last then moves to the parity bit.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   word input handshake, in_word = NBIT+1-bit word
//   out_valid/out_ready bit output handshake
//   out_bit             current serial bit
//   out_first/out_last  frame markers for the current bit
//   word_cnt            completed frames, wraps modulo 2^CNT_W
//   busy                FIFO non-empty or a frame in progress
module enc_serializer #(
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned CNT_W = 16,
   // Fixed by the encoder (constants.v); not overridable here.
   localparam int unsigned NBIT  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBIT:0]    in_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_first,
   output logic             out_last,
   output logic [CNT_W-1:0] word_cnt,
   output logic             busy
);

   localparam int unsigned W  = NBIT + 1;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = $clog2(W);

`ifdef ENC_SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t        state;
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] fcount;
   logic [W-1:0]  sreg;
   logic [BW-1:0] bit_idx;
   logic [W-1:0]  head;
   logic          empty, push, pop, frame_done;
`ifdef ENC_SER_PARITY_EN
   logic          par;
`endif

   assign empty    = (fcount == '0);
   assign in_ready = (fcount < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign head     = mem[rptr];
   assign busy     = !empty || (state != IDLE);

`ifdef ENC_SER_PARITY_EN
   assign frame_done = (state == PAR) && out_ready;
`else
   assign frame_done = (state == SHIFT) && out_ready && (bit_idx == '0);
`endif

   // The head is popped either from IDLE or on the completing handshake, so
   // consecutive frames run back to back without an idle cycle.
   assign pop = !empty && ((state == IDLE) || frame_done);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr   <= '0;
         rptr   <= '0;
         fcount <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   fcount <= fcount + CW'(1);
            2'b01:   fcount <= fcount - CW'(1);
            default: fcount <= fcount;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_idx   <= '0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         word_cnt  <= '0;
`ifdef ENC_SER_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         if (frame_done) word_cnt <= word_cnt + CNT_W'(1);

         if (pop) begin
            state     <= SHIFT;
            sreg      <= head;
            bit_idx   <= BW'(NBIT);
            out_valid <= 1'b1;
            out_bit   <= head[NBIT];
            out_first <= 1'b1;
            out_last  <= 1'b0;
`ifdef ENC_SER_PARITY_EN
            par       <= ^head;
`endif
         end else if (frame_done) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
         end else if ((state == SHIFT) && out_ready) begin
            if (bit_idx != '0) begin
               sreg      <= {sreg[NBIT-1:0], 1'b0};
               bit_idx   <= bit_idx - BW'(1);
               out_bit   <= sreg[NBIT-1];
               out_first <= 1'b0;
`ifdef ENC_SER_PARITY_EN
               out_last  <= 1'b0;
`else
               out_last  <= (bit_idx == BW'(1));
`endif
            end
`ifdef ENC_SER_PARITY_EN
            else begin
               state     <= PAR;
               out_bit   <= par;
               out_first <= 1'b0;
               out_last  <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_enc_serializer.sv
// Scoreboard bench for enc_serializer. Expected bits are queued when a word is
// sent. A negedge monitor pops and compares on every bit handshake.
// CNT_W is overridden to 4 so the counter wrap is reachable in a short run.
module tb_enc_serializer;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [8:0]    in_word = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_bit, out_first, out_last;
   logic [CW-1:0] word_cnt;
   logic          busy;

   int            tests = 0;
   int            fails = 0;
   bit            mon_en = 1'b1;
   logic [2:0]    expq [$];
   logic [CW-1:0] exp_cnt = '0;

   enc_serializer #(.DEPTH(2), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
      .out_first(out_first), .out_last(out_last),
      .word_cnt(word_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Issue one word; queue its expected frame when chk is set.
   task automatic send(input logic [8:0] w, input bit chk);
      int n = 0;
      if (chk) begin
         for (int i = 8; i >= 0; i--) begin
`ifdef ENC_SER_PARITY_EN
            expq.push_back({w[i], i == 8, 1'b0});
`else
            expq.push_back({w[i], i == 8, i == 0});
`endif
         end
`ifdef ENC_SER_PARITY_EN
         expq.push_back({^w, 1'b0, 1'b1});
`endif
         exp_cnt = exp_cnt + CW'(1);
      end
      in_word  = w;
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("send_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 500);
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: compare each handshaken bit against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin
         tests++;
         if (expq.size() == 0) begin
            fails++;
            $display("FAIL bit_unexpected: got %b%b%b expected none", out_bit, out_first, out_last);
         end else begin
            logic [2:0] e;
            e = expq.pop_front();
            if ({out_bit, out_first, out_last} !== e) begin
               fails++;
               $display("FAIL bit_first_last: got %b%b%b expected %b", out_bit, out_first, out_last, e);
            end
         end
      end
   end

   initial begin
      int held;
      // Reset state
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_bit",   {31'd0, out_bit},   32'd0);
      check("rst_first",     {31'd0, out_first}, 32'd0);
      check("rst_last",      {31'd0, out_last},  32'd0);
      check("rst_word_cnt",  {28'd0, word_cnt},  32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single word 256 with one cycle latency, no bypass
      send(9'd256, 1'b1);
      check("lat_no_bypass", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_valid", {29'd0, out_valid, out_first, out_bit}, 32'b111);
      wait_idle();
      check("cnt_single", {28'd0, word_cnt}, 32'd1);

      // Back-to-back 255, 510: 18 consecutive valid cycles
      @(posedge clk); #1;
      send(9'd255, 1'b1);
      send(9'd510, 1'b1);
      held = 0;
      for (int i = 0; i < 18; i++) begin
         if (out_valid) held++;
         @(posedge clk); #1;
      end
      check("no_bubble", held, 32'd18);
      wait_idle();
      check("cnt_b2b", {28'd0, word_cnt}, 32'd3);

      // Stall 5 cycles on the 3rd bit of 448
      @(posedge clk); #1;
      send(9'd448, 1'b1);
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      held = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid && out_bit && !out_first && !out_last) held++;
         @(posedge clk); #1;
      end
      check("stall_hold", held, 32'd5);
      out_ready = 1'b1;
      wait_idle();
      check("cnt_stall", {28'd0, word_cnt}, {28'd0, exp_cnt});

      // FIFO full: one word in the shifter plus DEPTH buffered
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(9'h155, 1'b1);
      send(9'h0AA, 1'b1);
      send(9'h1F0, 1'b1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      fork
         send(9'h00F, 1'b1);
      join_none
      held = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (!in_ready) held++;
      end
      check("full_held", held, 32'd4);
      out_ready = 1'b1;
      wait_idle();
      check("cnt_full", {28'd0, word_cnt}, {28'd0, exp_cnt});
      check("q_empty_pre_rst", expq.size(), 32'd0);

      // Async reset mid-frame at bit 5
      @(posedge clk); #1;
      mon_en = 1'b0;
      send(9'h1A5, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      check("arst_valid",    {31'd0, out_valid}, 32'd0);
      check("arst_busy",     {31'd0, busy},      32'd0);
      check("arst_word_cnt", {28'd0, word_cnt},  32'd0);
      check("arst_in_ready", {31'd0, in_ready},  32'd1);
      #3;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      send(9'h0F3, 1'b1);
      wait_idle();
      check("cnt_post_rst", {28'd0, word_cnt}, 32'd1);

      // Counter wrap: 15 more frames takes a 4-bit count from 1 to 0
      @(posedge clk); #1;
      for (int i = 1; i <= 15; i++) send(9'((i * 37) % 512), 1'b1);
      wait_idle();
      check("cnt_wrap", {28'd0, word_cnt}, 32'd0);
      check("cnt_model", {28'd0, word_cnt}, {28'd0, exp_cnt});
      check("q_empty_end", expq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
